// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// The optional back-to-back mode (ALU_ARB_BACK2BACK_EN) lives in alu_arbiter.sv.
package alu_arb_pkg;

   localparam int DEF_W   = 32;
   localparam int DEF_OPW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Opcodes understood by the external ALU; this block passes them through unchecked
   localparam logic [DEF_OPW-1:0] OP_ADD = 4'b0000;
   localparam logic [DEF_OPW-1:0] OP_SUB = 4'b0001;
   localparam logic [DEF_OPW-1:0] OP_AND = 4'b0010;
   localparam logic [DEF_OPW-1:0] OP_OR  = 4'b0011;
   localparam logic [DEF_OPW-1:0] OP_XOR = 4'b0100;
   localparam logic [DEF_OPW-1:0] OP_SLT = 4'b0101;
   localparam logic [DEF_OPW-1:0] OP_SLL = 4'b1000;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the requester
// that was not granted last. Grant is one-hot or zero.
module rr_arbiter_2 (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       last,
   input  logic       en,
   output logic [1:0] grant
);

   // pick requester 0 unless only 1 is valid or 0 won the previous tie
   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (valid0 && (!valid1 || last)) grant[0] = 1'b1;
         else if (valid1)                 grant[1] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters.
// Operands are registered to the ALU, the result is captured one cycle later
// and offered on a single response channel tagged with the requester ID.
// Define ALU_ARB_BACK2BACK_EN to let a response handshake overlap with the
// next request handshake (1 op per 2 cycles instead of 1 per 3).
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int W   = DEF_W,
   parameter int OPW = DEF_OPW
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic [OPW-1:0] req0_op,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   input  logic [OPW-1:0] req1_op,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [W-1:0]   rsp_result,
   output logic           rsp_zero,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic [OPW-1:0] alu_control,
   input  logic [W-1:0]   alu_result,
   input  logic           alu_zero
);

   state_t     state, state_nxt;
   logic       last;
   logic       id;
   logic       arb_en;
   logic [1:0] grant;
   logic       hs;
   logic       gid;

`ifdef ALU_ARB_BACK2BACK_EN
   // a draining response frees the ALU in the same cycle
   assign arb_en = !reset && ((state == IDLE) || (state == RESP && rsp_ready));
`else
   assign arb_en = !reset && (state == IDLE);
`endif

   rr_arbiter_2 u_arb (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .last   (last),
      .en     (arb_en),
      .grant  (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign hs         = grant[0] | grant[1];
   assign gid        = grant[1];

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state: accept -> one ALU cycle -> hold response until consumed
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = hs ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // register the granted operands; they hold until the next grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last        <= 1'b1;
         id          <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_control <= '0;
      end else if (hs) begin
         last        <= gid;
         id          <= gid;
         alu_a       <= gid ? req1_a  : req0_a;
         alu_b       <= gid ? req1_b  : req0_b;
         alu_control <= gid ? req1_op : req0_op;
      end
   end

   // capture ALU output after its single cycle, release on consumer handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else if (state == EXEC) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= id;
         rsp_result <= alu_result;
         rsp_zero   <= alu_zero;
      end else if (state == RESP && rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a transaction-level model predicts grants,
// response timing and results; a monitor pops expectations on each response.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int W = 32;
   localparam int OPW = 4;
`ifdef ALU_ARB_BACK2BACK_EN
   localparam int GAP = 2;
   localparam bit B2B = 1'b1;
`else
   localparam int GAP = 3;
   localparam bit B2B = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic req0_valid, req1_valid, req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [OPW-1:0] req0_op, req1_op;
   logic rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
   logic [OPW-1:0] alu_control;
   logic alu_zero;

   always #5 clk = ~clk;

   alu_arbiter #(.W(W), .OPW(OPW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OPW-1:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLL:  return a << b[4:0];
         default: return '0;
      endcase
   endfunction

   // external ALU stand-in
   always_comb begin
      alu_result = alu_fn(alu_a, alu_b, alu_control);
      alu_zero   = (alu_result == '0);
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: condition not reached within bound (t=%0t)", nm, $time);
   endtask

   // reference model state: one op outstanding at most, aged in cycles
   typedef struct packed { logic id; logic zero; logic [W-1:0] res; } exp_t;
   exp_t exp_q[$];
   bit   mon_en = 1'b0;
   bit   busy;
   int   age;
   bit   mlast;
   int   n_acc = 0;
   logic [W-1:0] ea, eb;
   logic [OPW-1:0] eop;

   logic   got_id[$];
   logic   got_zero[$];
   logic [W-1:0] got_res[$];
   int     got_cyc[$];

   // model: predict response visibility, grants and held ALU operands
   always @(negedge clk) begin
      if (mon_en) begin
         bit rsp_exp, avail, g0, g1, gid;
         logic [W-1:0] r;
         if (busy) age++;
         rsp_exp = busy && (age >= 2);
         chk("rsp_valid", rsp_valid, rsp_exp);
         chk("alu_a", alu_a, ea);
         chk("alu_b", alu_b, eb);
         chk("alu_control", alu_control, eop);
         avail = !busy || (B2B && rsp_exp && rsp_ready);
         g0 = 0; g1 = 0;
         if (avail) begin
            if (req0_valid && req1_valid) begin g0 = mlast; g1 = !mlast; end
            else begin g0 = req0_valid; g1 = req1_valid; end
         end
         chk("req0_ready", req0_ready, g0);
         chk("req1_ready", req1_ready, g1);
         if (rsp_exp && rsp_ready) busy = 0;
         if (g0 || g1) begin
            gid = g1;
            ea  = gid ? req1_a : req0_a;
            eb  = gid ? req1_b : req0_b;
            eop = gid ? req1_op : req0_op;
            r   = alu_fn(ea, eb, eop);
            exp_q.push_back('{id: gid, zero: (r == '0), res: r});
            busy = 1; age = 0; mlast = gid; n_acc++;
         end
      end
   end

   // monitor: stability under backpressure, scoreboard compare on handshake
   bit hold_v = 0;
   logic hold_id, hold_zero;
   logic [W-1:0] hold_res;
   always @(negedge clk) begin
      if (!mon_en) hold_v = 0;
      else if (rsp_valid) begin
         if (hold_v) begin
            chk("hold rsp_id", rsp_id, hold_id);
            chk("hold rsp_result", rsp_result, hold_res);
            chk("hold rsp_zero", rsp_zero, hold_zero);
         end
         if (rsp_ready) begin
            exp_t e;
            hold_v = 0;
            if (exp_q.size() == 0) fail_now("unexpected response");
            else begin
               e = exp_q.pop_front();
               chk("rsp_id", rsp_id, e.id);
               chk("rsp_result", rsp_result, e.res);
               chk("rsp_zero", rsp_zero, e.zero);
            end
            got_id.push_back(rsp_id);
            got_res.push_back(rsp_result);
            got_zero.push_back(rsp_zero);
            got_cyc.push_back(cyc);
         end else begin
            hold_v = 1; hold_id = rsp_id; hold_res = rsp_result; hold_zero = rsp_zero;
         end
      end else hold_v = 0;
   end

   // ---------------- stimulus ----------------
   bit drop = 1'b1;
   bit rnd_ops = 1'b0;

   function automatic logic [OPW-1:0] rnd_op();
      logic [OPW-1:0] tbl [8];
      tbl = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL, 4'hF};
      return tbl[$urandom_range(0, 7)];
   endfunction

   task automatic randomize_ops();
      req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_a = $urandom; req1_b = $urandom;
      req0_op = rnd_op(); req1_op = rnd_op();
   endtask

   task automatic cycle();
      bit a0, a1;
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (drop) begin
         if (a0) req0_valid = 0;
         if (a1) req1_valid = 0;
      end
      if (rnd_ops) randomize_ops();
   endtask

   task automatic wait_got(input int n, input int max, input string nm);
      for (int i = 0; i < max && got_id.size() < n; i++) cycle();
      if (got_id.size() < n) fail_now(nm);
   endtask

   task automatic wait_idle();
      req0_valid = 0; req1_valid = 0; rsp_ready = 1;
      for (int i = 0; i < 20 && (busy || exp_q.size() != 0); i++) cycle();
      if (busy || exp_q.size() != 0) fail_now("drain");
   endtask

   task automatic do_reset();
      mon_en = 0;
      reset = 1; req0_valid = 1; req1_valid = 1; rsp_ready = 1;
      #2;
      chk("rst req0_ready", req0_ready, 0);
      chk("rst req1_ready", req1_ready, 0);
      chk("rst rsp_valid", rsp_valid, 0);
      chk("rst rsp_id", rsp_id, 0);
      chk("rst rsp_result", rsp_result, 0);
      chk("rst rsp_zero", rsp_zero, 0);
      chk("rst alu_a", alu_a, 0);
      chk("rst alu_b", alu_b, 0);
      chk("rst alu_control", alu_control, 0);
      @(posedge clk); #1;
      busy = 0; age = 0; mlast = 1; ea = 0; eb = 0; eop = 0;
      exp_q.delete();
      req0_valid = 0; req1_valid = 0;
      reset = 0;
      mon_en = 1;
   endtask

   initial begin
      int base, acc0;
      reset = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
      req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
      do_reset();

      // single op: 5 + 3 from requester 0
      base = got_id.size();
      req0_a = 5; req0_b = 3; req0_op = OP_ADD; req0_valid = 1;
      wait_got(base + 1, 20, "single op");
      if (got_id.size() > base) begin
         chk("single result", got_res[base], 8);
         chk("single zero", got_zero[base], 0);
         chk("single id", got_id[base], 0);
      end
      wait_idle();

      // tie from reset: requester 0 first
      do_reset();
      base = got_id.size();
      req0_a = 7; req0_b = 7; req0_op = OP_SUB;
      req1_a = 32'hF0; req1_b = 32'h0F; req1_op = OP_OR;
      req0_valid = 1; req1_valid = 1;
      wait_got(base + 2, 30, "tie");
      if (got_id.size() >= base + 2) begin
         chk("tie first id", got_id[base], 0);
         chk("tie first result", got_res[base], 0);
         chk("tie first zero", got_zero[base], 1);
         chk("tie second id", got_id[base + 1], 1);
         chk("tie second result", got_res[base + 1], 32'hFF);
      end
      wait_idle();

      // fairness: both held valid for six ops
      base = got_id.size();
      drop = 0; rnd_ops = 1; randomize_ops();
      req0_valid = 1; req1_valid = 1;
      wait_got(base + 6, 60, "fairness");
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 6 && base + i < got_id.size(); i++)
         chk($sformatf("fair id %0d", i), got_id[base + i], i % 2);
      wait_idle();

      // backpressure: response held, no new grant while blocked
      drop = 1; rsp_ready = 0; req0_valid = 1;
      for (int i = 0; i < 20 && !(busy && age >= 2); i++) cycle();
      if (!(busy && age >= 2)) fail_now("bp response");
      req0_valid = 1; req1_valid = 1; drop = 0;
      acc0 = n_acc;
      for (int i = 0; i < 5; i++) cycle();
      chk("bp no accept", n_acc, acc0);
      base = got_id.size();
      req0_valid = 0; req1_valid = 0; drop = 1; rsp_ready = 1;
      wait_got(base + 1, 10, "bp release");
      wait_idle();

      // reset while the op is in EXEC
      acc0 = n_acc;
      req1_valid = 1;
      for (int i = 0; i < 20 && n_acc == acc0; i++) cycle();
      if (n_acc == acc0) fail_now("pre-reset accept");
      do_reset();
      base = got_id.size();
      for (int i = 0; i < 4; i++) cycle();
      chk("no rsp after reset", got_id.size(), base);
      req0_valid = 1; req1_valid = 1;
      wait_got(base + 2, 30, "post-reset tie");
      if (got_id.size() >= base + 2) begin
         chk("post-reset tie id0", got_id[base], 0);
         chk("post-reset tie id1", got_id[base + 1], 1);
      end
      wait_idle();

      // streaming from requester 1: response spacing
      base = got_id.size();
      drop = 0; rsp_ready = 1; req1_valid = 1;
      wait_got(base + 5, 40, "stream");
      req1_valid = 0;
      for (int i = 1; i < 5 && base + i < got_id.size(); i++) begin
         chk($sformatf("stream gap %0d", i), got_cyc[base + i] - got_cyc[base + i - 1], GAP);
         chk($sformatf("stream id %0d", i), got_id[base + i], 1);
      end
      wait_idle();

      // random traffic
      for (int i = 0; i < 300; i++) begin
         req0_valid = $urandom_range(0, 1);
         req1_valid = $urandom_range(0, 1);
         rsp_ready  = ($urandom_range(0, 3) != 0);
         cycle();
      end
      wait_idle();
      chk("queue empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
